keypad_scanner: RTL and testbench

Scans the 4x4 Pmod keypad matrix, synchronizes and debounces the row returns, and presents a stable 4-bit key code to the downstream keypad decoder that converts it to a tone divide factor. One column is driven low at a time. A key code is accepted only after it is seen identically for DEBOUNCE_SCANS consecutive full scans. Each accepted press produces a one-cycle strobe.

---
 rtl/keypad_scanner_if.sv | 34 +++
 rtl/keypad_scanner.sv | 203 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Groups the keypad matrix pins and the key-code outputs of keypad_scanner.
//   Signals:
//     rows_i        : row returns from the keypad, active-low (asynchronous)
//     cols_o        : column drives, active-low, at most one low at a time
//     key_value_o   : last accepted key code
//     key_pressed_o : high while a debounced key is held
//     key_valid_o   : one-cycle pulse on each newly accepted press
//   Modports:
//     master : the scanner (drives columns and key outputs, reads rows)
//     slave  : the keypad/decoder side (drives rows, reads the rest)
interface keypad_scanner_if;
    logic [3:0] rows_i;
    logic [3:0] cols_o;
    logic [3:0] key_value_o;
    logic       key_pressed_o;
    logic       key_valid_o;

    modport master (
        input  rows_i,
        output cols_o,
        output key_value_o,
        output key_pressed_o,
        output key_valid_o
    );

    modport slave (
        output rows_i,
        input  cols_o,
        input  key_value_o,
        input  key_pressed_o,
        input  key_valid_o
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 keypad one column at a time, synchronizes and debounces the
//   row returns, and presents a stable 4-bit key code with a one-cycle strobe
//   on each accepted press.
//   Parameters:
//     SETTLE_CYCLES  : clocks each column is driven before sampling (>= 4)
//     DEBOUNCE_SCANS : identical full scans needed to accept a change (>= 1)
//   Ports:
//     clk_i : system clock
//     rst_i : synchronous active-high reset
//     kp    : keypad_scanner_if.master (rows in; columns and key outputs out)
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 8,
    parameter int DEBOUNCE_SCANS = 3
) (
    input logic              clk_i,
    input logic              rst_i,
    keypad_scanner_if.master kp
);

    localparam int WIN_W = $clog2(SETTLE_CYCLES);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        RES_NONE,
        RES_KEY,
        RES_MULTI
    } scan_res_t;

    // Key legend for capture bit index {col, row}.
    function automatic logic [3:0] key_code(input logic [3:0] idx);
        logic [3:0] code;
        unique case ({idx[1:0], idx[3:2]})   // {row, col}
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] bits);
        logic [4:0] sum;
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            sum = sum + 5'(bits[i]);
        end
        return sum;
    endfunction

    // With exactly one bit set the OR collapses to that key's code;
    // with none set it yields 0, which is also the NONE candidate code.
    function automatic logic [3:0] single_code(input logic [15:0] bits);
        logic [3:0] code;
        code = '0;
        for (int i = 0; i < 16; i++) begin
            if (bits[i]) begin
                code = code | key_code(4'(i));
            end
        end
        return code;
    endfunction

    logic [3:0]       rows_meta;
    logic [3:0]       rows_s;
    logic [WIN_W-1:0] win;
    logic [1:0]       col;
    logic [15:0]      cap;          // bit {col, row} = key seen pressed

    logic             cand_key;     // 0 = NONE, 1 = KEY(cand_code)
    logic [3:0]       cand_code;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       key_value;
    logic             pressed;
    logic             valid;

    logic             window_end;
    logic             scan_end;
    logic [15:0]      scan_bits;
    logic [4:0]       ones;
    scan_res_t        res;
    logic [3:0]       res_code;
    logic             same;

    logic             cand_key_nxt;
    logic [3:0]       cand_code_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       key_value_nxt;
    logic             pressed_nxt;
    logic             valid_nxt;

    assign window_end = (win == WIN_LAST);
    assign scan_end   = window_end && (col == 2'd3);

    // Column 3 is captured on the same edge the scan is judged, so its
    // bits come straight from the synchronizer instead of the capture reg.
    assign scan_bits  = {~rows_s, cap[11:0]};
    assign ones       = popcount16(scan_bits);
    assign res_code   = single_code(scan_bits);

    always_comb begin
        res = RES_MULTI;
        if (ones == 5'd0) begin
            res = RES_NONE;
        end else if (ones == 5'd1) begin
            res = RES_KEY;
        end
    end

    assign same = (res != RES_MULTI) && ((res == RES_KEY) == cand_key) &&
                  (res_code == cand_code);

    always_comb begin
        cand_key_nxt  = cand_key;
        cand_code_nxt = cand_code;
        cnt_nxt       = cnt;
        key_value_nxt = key_value;
        pressed_nxt   = pressed;
        valid_nxt     = 1'b0;
        if (scan_end) begin
            if (res == RES_MULTI) begin
                cand_key_nxt  = 1'b0;
                cand_code_nxt = '0;
                cnt_nxt       = '0;
            end else begin
                if (same) begin
                    if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else begin
                    cand_key_nxt  = (res == RES_KEY);
                    cand_code_nxt = res_code;
                    cnt_nxt       = CNT_W'(1);
                end
                // Fire only on the scan that brings the count to the limit;
                // a result already saturated does not accept again.
                if ((cnt_nxt == CNT_MAX) && !(same && (cnt == CNT_MAX))) begin
                    if (res == RES_KEY) begin
                        if (!pressed || (res_code != key_value)) begin
                            key_value_nxt = res_code;
                            pressed_nxt   = 1'b1;
                            valid_nxt     = 1'b1;
                        end
                    end else begin
                        pressed_nxt = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rows_meta <= '0;
            rows_s    <= '0;
            win       <= '0;
            col       <= '0;
            cap       <= '0;
            cand_key  <= 1'b0;
            cand_code <= '0;
            cnt       <= '0;
            key_value <= '0;
            pressed   <= 1'b0;
            valid     <= 1'b0;
        end else begin
            rows_meta <= kp.rows_i;
            rows_s    <= rows_meta;
            if (window_end) begin
                win                     <= '0;
                col                     <= col + 2'd1;
                cap[{col, 2'b00} +: 4]  <= ~rows_s;
            end else begin
                win <= win + WIN_W'(1);
            end
            cand_key  <= cand_key_nxt;
            cand_code <= cand_code_nxt;
            cnt       <= cnt_nxt;
            key_value <= key_value_nxt;
            pressed   <= pressed_nxt;
            valid     <= valid_nxt;
        end
    end

    assign kp.cols_o        = ~(4'b0001 << col);
    assign kp.key_value_o   = key_value;
    assign kp.key_pressed_o = pressed;
    assign kp.key_valid_o   = valid;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Bench for keypad_scanner with SETTLE_CYCLES=8, DEBOUNCE_SCANS=3.
//   A combinational keypad model turns a pressed-key mask into row returns
//   from the driven columns. Keys change only at scan boundaries.
module tb_keypad_scanner;

    localparam int SETTLE = 8;
    localparam int DEB    = 3;
    localparam int PERIOD = 4 * SETTLE;

    logic clk;
    logic rst;
    logic [15:0] keys;        // bit r*4+c = key at row r, column c pressed
    logic [3:0]  rows_drv;

    keypad_scanner_if kp_if();

    keypad_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .kp   (kp_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Key legend indexed by r*4+c.
    logic [3:0] legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'h0, 4'hF, 4'hE, 4'hD};

    always_comb begin
        rows_drv = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && (kp_if.cols_o[c] == 1'b0)) begin
                    rows_drv[r] = 1'b0;
                end
            end
        end
    end
    assign kp_if.rows_i = rows_drv;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [15:0] km(input logic [3:0] code);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (legend[i] == code) m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: per scan, a result is NONE (-1), MULTI (-2) or
    // a key code; a press/release is accepted on the scan where the run of
    // identical results since the last change or MULTI reaches DEB.
    int         m_prev;
    int         m_run;
    logic [3:0] m_val;
    logic       m_pr;
    logic       m_vld;

    task automatic model_reset();
        m_prev = -1;
        m_run  = 0;
        m_val  = 4'h0;
        m_pr   = 1'b0;
        m_vld  = 1'b0;
    endtask

    task automatic model_scan(input logic [15:0] k);
        int n;
        int res;
        n   = 0;
        res = -1;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) begin
                n++;
                res = int'(legend[i]);
            end
        end
        if (n > 1) res = -2;
        m_vld = 1'b0;
        if (res == -2) begin
            m_prev = -1;
            m_run  = 0;
        end else begin
            if (res == m_prev) m_run++;
            else begin
                m_prev = res;
                m_run  = 1;
            end
            if (m_run == DEB) begin
                if (res == -1) m_pr = 1'b0;
                else if (!m_pr || (int'(m_val) != res)) begin
                    m_val = 4'(res);
                    m_pr  = 1'b1;
                    m_vld = 1'b1;
                end
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cols"},    int'(kp_if.cols_o), 4'b1110);
        check({tag, "_value"},   int'(kp_if.key_value_o), 0);
        check({tag, "_pressed"}, int'(kp_if.key_pressed_o), 0);
        check({tag, "_valid"},   int'(kp_if.key_valid_o), 0);
    endtask

    // Leaves the bench #1 into cycle 0 (first cycle with rst low).
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
    endtask

    // One full scan with the given keys held; returns outputs as seen at
    // the first cycle of the next scan.
    task automatic run_scan(input logic [15:0] k, output logic [3:0] v,
                            output logic p, output logic vld);
        int colbad;
        int stray;
        logic [3:0] exp_cols;
        colbad = 0;
        stray  = 0;
        keys   = k;
        for (int i = 1; i <= PERIOD; i++) begin
            @(posedge clk);
            #1;
            exp_cols = ~(4'b0001 << ((i % PERIOD) / SETTLE));
            if (kp_if.cols_o !== exp_cols) colbad++;
            if ((i < PERIOD) && (kp_if.key_valid_o !== 1'b0)) stray++;
        end
        check("cols_walk", colbad, 0);
        check("mid_scan_pulse", stray, 0);
        v   = kp_if.key_value_o;
        p   = kp_if.key_pressed_o;
        vld = kp_if.key_valid_o;
    endtask

    typedef struct {
        logic [15:0] k;
        logic [3:0]  val;
        logic        pr;
        logic        vld;
        string       tag;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [15:0] k, input logic [3:0] val,
                       input logic pr, input logic vld, input string tag);
        vec_t e;
        e.k   = k;
        e.val = val;
        e.pr  = pr;
        e.vld = vld;
        e.tag = tag;
        tbl.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v;
        logic       p;
        logic       vld;
        logic [15:0] rk;
        logic [15:0] prev_k;

        rst  = 1'b1;
        keys = '0;

        // Idle scans, single press of 5, release, re-press.
        add('0,          4'h0, 1'b0, 1'b0, "idle");
        add('0,          4'h0, 1'b0, 1'b0, "idle");
        add(km(4'h5),    4'h0, 1'b0, 1'b0, "press5_s1");
        add(km(4'h5),    4'h0, 1'b0, 1'b0, "press5_s2");
        add(km(4'h5),    4'h5, 1'b1, 1'b1, "press5_acc");
        for (int i = 0; i < 7; i++) add(km(4'h5), 4'h5, 1'b1, 1'b0, "press5_hold");
        add('0,          4'h5, 1'b1, 1'b0, "rel5_s1");
        add('0,          4'h5, 1'b1, 1'b0, "rel5_s2");
        add('0,          4'h5, 1'b0, 1'b0, "rel5_acc");
        add(km(4'h5),    4'h5, 1'b0, 1'b0, "repress5_s1");
        add(km(4'h5),    4'h5, 1'b0, 1'b0, "repress5_s2");
        add(km(4'h5),    4'h5, 1'b1, 1'b1, "repress5_acc");
        // Bounce on 9.
        add(km(4'h9),    4'h5, 1'b1, 1'b0, "bounce9_s1");
        add(km(4'h9),    4'h5, 1'b1, 1'b0, "bounce9_s2");
        add('0,          4'h5, 1'b1, 1'b0, "bounce9_gap");
        add(km(4'h9),    4'h5, 1'b1, 1'b0, "bounce9_s4");
        add(km(4'h9),    4'h5, 1'b1, 1'b0, "bounce9_s5");
        add(km(4'h9),    4'h9, 1'b1, 1'b1, "bounce9_acc");
        // Multi-key, then direct changes.
        add(km(4'hA),    4'h9, 1'b1, 1'b0, "pressA_s1");
        add(km(4'hA),    4'h9, 1'b1, 1'b0, "pressA_s2");
        add(km(4'hA),    4'hA, 1'b1, 1'b1, "pressA_acc");
        for (int i = 0; i < 5; i++) add(km(4'hA) | km(4'h2), 4'hA, 1'b1, 1'b0, "multi_A2");
        add(km(4'h2),    4'hA, 1'b1, 1'b0, "only2_s1");
        add(km(4'h2),    4'hA, 1'b1, 1'b0, "only2_s2");
        add(km(4'h2),    4'h2, 1'b1, 1'b1, "only2_acc");
        add(km(4'hD),    4'h2, 1'b1, 1'b0, "toD_s1");
        add(km(4'hD),    4'h2, 1'b1, 1'b0, "toD_s2");
        add(km(4'hD),    4'hD, 1'b1, 1'b1, "toD_acc");
        add(km(4'hD),    4'hD, 1'b1, 1'b0, "holdD");
        add('0,          4'hD, 1'b1, 1'b0, "relD_s1");
        add('0,          4'hD, 1'b1, 1'b0, "relD_s2");
        add('0,          4'hD, 1'b0, 1'b0, "relD_acc");

        do_reset();
        foreach (tbl[i]) begin
            run_scan(tbl[i].k, v, p, vld);
            check({tbl[i].tag, "_value"},   int'(v),   int'(tbl[i].val));
            check({tbl[i].tag, "_pressed"}, int'(p),   int'(tbl[i].pr));
            check({tbl[i].tag, "_valid"},   int'(vld), int'(tbl[i].vld));
        end

        // Reset mid-debounce: accept 5, then hold 7 and reset during scan 2.
        do_reset();
        for (int s = 0; s < DEB; s++) run_scan(km(4'h5), v, p, vld);
        check("pre_rst_value", int'(v), 5);
        run_scan(km(4'h7), v, p, vld);
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("mid_rst");
        rst = 1'b0;
        for (int s = 1; s <= DEB + 1; s++) begin
            run_scan(km(4'h7), v, p, vld);
            check("rst7_value",   int'(v),   (s >= DEB) ? 7 : 0);
            check("rst7_pressed", int'(p),   (s >= DEB) ? 1 : 0);
            check("rst7_valid",   int'(vld), (s == DEB) ? 1 : 0);
        end

        // Randomized scans against the reference model.
        do_reset();
        model_reset();
        prev_k = '0;
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(99) < 60) begin
                rk = prev_k;
            end else begin
                int sel;
                sel = $urandom_range(99);
                rk  = '0;
                if (sel >= 25) rk[$urandom_range(15)] = 1'b1;
                if (sel >= 80) rk[$urandom_range(15)] = 1'b1;
            end
            prev_k = rk;
            model_scan(rk);
            run_scan(rk, v, p, vld);
            check("rand_value",   int'(v),   int'(m_val));
            check("rand_pressed", int'(p),   int'(m_pr));
            check("rand_valid",   int'(vld), int'(m_vld));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
